// File: rtl/pixel_pkg.sv
// Shared pixel-path constants: word width, RGB field positions and the
// decimate/repeat factor common to the decimator and the expander.
package pixel_pkg;

   localparam int unsigned PIX_W         = 24;
   localparam int unsigned R_MSB         = 23;
   localparam int unsigned R_LSB         = 16;
   localparam int unsigned G_MSB         = 15;
   localparam int unsigned G_LSB         = 8;
   localparam int unsigned B_MSB         = 7;
   localparam int unsigned B_LSB         = 0;
   localparam int unsigned REPEAT_FACTOR = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } rep_state_e;

   function automatic logic [PIX_W-1:0] rgb_pack(input logic [7:0] r,
                                                 input logic [7:0] g,
                                                 input logic [7:0] b);
      logic [PIX_W-1:0] w;
      w              = '0;
      w[R_MSB:R_LSB] = r;
      w[G_MSB:G_LSB] = g;
      w[B_MSB:B_LSB] = b;
      return w;
   endfunction

endpackage

// File: rtl/pixel_hold_reg.sv
// Single-entry pending register: load fills it, unload empties it,
// clr flushes it. Load and unload are never asserted together.
module pixel_hold_reg
   import pixel_pkg::*;
#(
   parameter int unsigned DATA_W = PIX_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              load,
   input  logic              unload,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full
);

   logic [DATA_W-1:0] data_q, data_d;
   logic              full_q, full_d;

   always_comb begin
      data_d = data_q;
      full_d = full_q;
      if (clr) begin
         data_d = '0;
         full_d = 1'b0;
      end else if (load) begin
         data_d = din;
         full_d = 1'b1;
      end else if (unload) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         full_q <= full_d;
      end
   end

   assign dout = data_q;
   assign full = full_q;

endmodule

// File: rtl/pixel_repeat_x4.sv
// Horizontal pixel expander: each accepted word is emitted FACTOR times,
// with a pending slot so the stream stays gap-free under full-rate reads.
module pixel_repeat_x4
   import pixel_pkg::*;
#(
   parameter int unsigned DATA_W = PIX_W,
   parameter int unsigned FACTOR = REPEAT_FACTOR,
   parameter int unsigned CNT_W  = $clog2(FACTOR)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sync_clr,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_first
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FACTOR - 1);

   rep_state_e        state_q, state_d;
   logic [DATA_W-1:0] cur_q, cur_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              first_q, first_d;

   logic              in_xfer, out_xfer, last_xfer;
   logic              hold_load, hold_unload, hold_full;
   logic [DATA_W-1:0] hold_data;

   // in_ready comes straight off the pending-full flop, so it is registered
   assign in_ready    = ~hold_full;
   assign in_xfer     = in_valid & in_ready;
   assign out_xfer    = out_valid & out_ready;
   assign last_xfer   = out_xfer & (cnt_q == CNT_LAST);
   assign hold_load   = ~sync_clr & in_xfer & (state_q == ST_EMIT) & ~last_xfer;
   assign hold_unload = ~sync_clr & last_xfer & hold_full;

   pixel_hold_reg #(
      .DATA_W (DATA_W)
   ) u_hold (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (sync_clr),
      .load   (hold_load),
      .unload (hold_unload),
      .din    (in_data),
      .dout   (hold_data),
      .full   (hold_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cur_q   <= '0;
         cnt_q   <= '0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      cnt_d   = cnt_q;
      first_d = first_q;
      if (sync_clr) begin
         state_d = ST_IDLE;
         cur_d   = '0;
         cnt_d   = '0;
         first_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (in_xfer) begin
                  state_d = ST_EMIT;
                  cur_d   = in_data;
                  cnt_d   = '0;
                  first_d = 1'b1;
               end
            end
            ST_EMIT: begin
               // Last copy: pending word first, then same-cycle bypass, else drain
               if (last_xfer) begin
                  cnt_d = '0;
                  if (hold_full) begin
                     cur_d   = hold_data;
                     first_d = 1'b1;
                  end else if (in_xfer) begin
                     cur_d   = in_data;
                     first_d = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                     first_d = 1'b0;
                  end
               end else if (out_xfer) begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  first_d = 1'b0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      out_valid = (state_q == ST_EMIT);
      out_data  = out_valid ? cur_q : '0;
      out_first = out_valid & first_q;
   end

endmodule

// File: tb/tb_pixel_repeat_x4.sv
// Bench for pixel_repeat_x4: directed scenarios plus random traffic checked
// against a queue model of accepted words and copies already emitted.
module tb_pixel_repeat_x4;
   import pixel_pkg::*;

   localparam int unsigned DW = PIX_W;
   localparam int unsigned F  = REPEAT_FACTOR;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          sync_clr  = 1'b0;
   logic          in_valid  = 1'b0;
   logic [DW-1:0] in_data   = '0;
   logic          out_ready = 1'b0;
   logic          in_ready, out_valid, out_first;
   logic [DW-1:0] out_data;

   int            checks = 0;
   int            errors = 0;

   // Model: words accepted but not yet fully emitted, head is the current one
   logic [DW-1:0] mq[$];
   int unsigned   copies = 0;
   int unsigned   nvalid = 0;
   int unsigned   nxfer  = 0;

   always #5 clk = ~clk;

   pixel_repeat_x4 #(
      .DATA_W (DW),
      .FACTOR (F)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sync_clr  (sync_clr),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_first (out_first)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic          e_valid;
      logic [DW-1:0] e_data;
      logic          e_first;
      e_valid = (mq.size() > 0);
      e_data  = e_valid ? mq[0] : '0;
      e_first = e_valid && (copies == 0);
      chk("out_valid", {23'd0, out_valid}, {23'd0, e_valid});
      chk("out_data", out_data, e_data);
      chk("out_first", {23'd0, out_first}, {23'd0, e_first});
      chk("in_ready", {23'd0, in_ready}, {23'd0, (mq.size() < 2)});
   endtask

   // One clock: update the model with the inputs seen at the edge, then check
   task automatic step();
      bit ix, ox;
      if (out_valid === 1'b1 && out_ready) nxfer++;
      @(posedge clk);
      ix = in_valid && (mq.size() < 2);
      ox = (mq.size() > 0) && out_ready;
      if (sync_clr) begin
         mq.delete();
         copies = 0;
      end else begin
         if (ox) begin
            copies++;
            if (copies == F) begin
               void'(mq.pop_front());
               copies = 0;
            end
         end
         if (ix) mq.push_back(in_data);
      end
      @(negedge clk);
      if (out_valid === 1'b1) nvalid++;
      check_outputs();
   endtask

   initial begin
      bit acc;
      int unsigned w;

      // Reset state
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_outputs();
      rst_n = 1'b1;
      @(negedge clk);
      check_outputs();

      // Single word, consumer always ready
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 24'hA1B2C3;
      nvalid    = 0;
      step();
      in_valid = 1'b0;
      chk("sw_first", {23'd0, out_first}, 24'd1);
      chk("sw_data", out_data, 24'hA1B2C3);
      repeat (6) step();
      chk("sw_valid_cycles", DW'(nvalid), DW'(F));

      // Back-to-back stream 1..4
      w = 1;
      nvalid = 0;
      for (int i = 0; i < 24; i++) begin
         in_valid = (w <= 4);
         in_data  = DW'(w);
         acc = in_valid && (mq.size() < 2);
         step();
         if (acc) w++;
      end
      in_valid = 1'b0;
      chk("b2b_valid_cycles", DW'(nvalid), DW'(4 * F));

      // Backpressure pattern 1,0,0,1 over two words
      nxfer = 0;
      in_data  = rgb_pack(8'h10, 8'h20, 8'h30);
      in_valid = 1'b1;
      out_ready = 1'b1;
      step();
      in_data = rgb_pack(8'h40, 8'h50, 8'h60);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 32; i++) begin
         out_ready = (i % 4 == 0) || (i % 4 == 3);
         step();
      end
      chk("bp_transfers", DW'(nxfer), DW'(2 * F));

      // Pending full: third offer held off until word 1 finishes
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 24'h111111;
      step();
      in_data = 24'h222222;
      step();
      in_data = 24'h333333;
      chk("pf_in_ready_low", {23'd0, in_ready}, 24'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         acc = in_valid && (mq.size() < 2);
         step();
         if (acc) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      repeat (12) step();

      // sync_clr on copy 2 with pending full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 24'hAAAAAA;
      step();
      in_data = 24'hBBBBBB;
      step();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (2) step();
      sync_clr = 1'b1;
      in_valid = 1'b1;
      in_data  = 24'hDDDDDD;
      step();
      sync_clr = 1'b0;
      chk("clr_valid", {23'd0, out_valid}, 24'd0);
      chk("clr_in_ready", {23'd0, in_ready}, 24'd1);
      chk("clr_data", out_data, 24'd0);
      in_data = 24'hEEEEEE;
      step();
      in_valid = 1'b0;
      chk("clr_next_first", {23'd0, out_first}, 24'd1);
      chk("clr_next_data", out_data, 24'hEEEEEE);
      repeat (6) step();

      // Async reset between clock edges mid-EMIT
      in_valid = 1'b1;
      in_data  = 24'h5A5A5A;
      step();
      in_valid = 1'b0;
      step();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {23'd0, out_valid}, 24'd0);
      chk("arst_data", out_data, 24'd0);
      chk("arst_first", {23'd0, out_first}, 24'd0);
      chk("arst_in_ready", {23'd0, in_ready}, 24'd1);
      mq.delete();
      copies = 0;
      @(negedge clk);
      check_outputs();
      rst_n = 1'b1;
      in_valid = 1'b1;
      in_data  = 24'hA1B2C3;
      nvalid   = 0;
      step();
      in_valid = 1'b0;
      chk("arst_sw_first", {23'd0, out_first}, 24'd1);
      repeat (6) step();
      chk("arst_sw_valid_cycles", DW'(nvalid), DW'(F));

      // Throughput: one word every F cycles, consumer always ready
      out_ready = 1'b1;
      nvalid = 0;
      for (int i = 0; i < 8 * F; i++) begin
         in_valid = (i % F == 0);
         in_data  = DW'($urandom);
         step();
      end
      in_valid = 1'b0;
      chk("tp_valid_cycles", DW'(nvalid), DW'(8 * F));
      repeat (6) step();

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         in_valid  = ($urandom_range(0, 99) < 60);
         in_data   = DW'($urandom);
         out_ready = ($urandom_range(0, 99) < 75);
         sync_clr  = ($urandom_range(0, 99) < 2);
         step();
      end
      sync_clr = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (12) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
